uart_tx_buf: RTL and testbench

- Transmit-side word buffer between bus_bridge and uart_ctrl.
- Accepts 32-bit words from the bus, stores them in a DEPTH-entry FIFO, and issues them to uart_ctrl one at a time on data_in/data_in_en.
- Issues the next word only after the current word's completion, signalled by a txd_valid rising edge; a bounded wait guards against a stalled transmitter.

---
 rtl/uart_tx_buf.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_buf.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Transmit word buffer: FIFO of bus words issued one at a time to uart_ctrl,
// pacing each word on the synchronised txd_valid completion edge.
module uart_tx_buf #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int EN_HOLD = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  output logic          full,
  output logic [AW:0]   level,
  input  logic          flush,
  output logic [31:0]   data_out,
  output logic          data_out_en,
  input  logic          txd_valid,
  output logic          busy,
  output logic          ovf,
  output logic          tmo,
  input  logic          err_clr,
  output logic [15:0]   sent_cnt
);

  localparam int HW = $clog2(EN_HOLD + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(EN_HOLD - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          en_q, en_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [15:0]   sent_q, sent_d;
  logic          ovf_q, ovf_d;
  logic          tmo_q, tmo_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic [31:0]   mem_q [DEPTH];

  logic empty, full_w, push, done, ovf_set, tmo_set;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_w = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push   = wr_en & ~full_w & ~flush;
  assign done   = sync2_q & ~sync3_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    en_d       = en_q;
    hold_d     = hold_q;
    wait_d     = wait_q;
    sent_d     = sent_q;
    ovf_set    = wr_en & full_w & ~flush;
    tmo_set    = 1'b0;
    if (flush) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      en_d     = 1'b0;
      hold_d   = '0;
      wait_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty) begin
            data_out_d = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            en_d       = 1'b1;
            hold_d     = '0;
            state_d    = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (hold_q == HOLD_LAST) begin
            en_d    = 1'b0;
            wait_d  = '0;
            state_d = S_WAIT;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_WAIT: begin
          // a completion in the final timeout cycle still counts
          if (done) begin
            sent_d  = sent_q + 16'd1;
            state_d = S_GAP;
          end else if (wait_q == WAIT_LAST) begin
            tmo_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_GAP: state_d = S_IDLE;
      endcase
    end
    ovf_d = ovf_set | (ovf_q & ~err_clr);
    tmo_d = tmo_set | (tmo_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_out_q <= '0;
      en_q       <= 1'b0;
      hold_q     <= '0;
      wait_q     <= '0;
      sent_q     <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_out_q <= data_out_d;
      en_q       <= en_d;
      hold_q     <= hold_d;
      wait_q     <= wait_d;
      sent_q     <= sent_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      sync1_q    <= txd_valid;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
    end
  end

  assign full        = full_w;
  assign level       = wr_ptr_q - rd_ptr_q;
  assign data_out    = data_out_q;
  assign data_out_en = en_q;
  assign busy        = (state_q != S_IDLE);
  assign ovf         = ovf_q;
  assign tmo         = tmo_q;
  assign sent_cnt    = sent_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: a word-queue model predicts issue order,
// occupancy and overflow; a monitor checks each issued word against it.
module tb_uart_tx_buf;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int EN_HOLD = 16;
  localparam int TIMEOUT = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [31:0]   wr_data = '0;
  logic          full;
  logic [AW:0]   level;
  logic          flush = 1'b0;
  logic [31:0]   data_out;
  logic          data_out_en;
  logic          txd_valid = 1'b0;
  logic          busy;
  logic          ovf;
  logic          tmo;
  logic          err_clr = 1'b0;
  logic [15:0]   sent_cnt;

  uart_tx_buf #(
    .DEPTH(DEPTH), .AW(AW), .EN_HOLD(EN_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .level(level), .flush(flush),
    .data_out(data_out), .data_out_en(data_out_en),
    .txd_valid(txd_valid), .busy(busy), .ovf(ovf), .tmo(tmo),
    .err_clr(err_clr), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_q[$];
  logic        model_ovf = 1'b0;
  logic        flush_seen = 1'b0;
  int          exp_sent = 0;

  logic        en_prev = 1'b0;
  logic        have_prev = 1'b0;
  int          hold_cnt = 0;
  int          low_cnt = 0;
  logic [31:0] cur_word = '0;
  logic        set_ovf;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // model: writes land on the edge, judged against occupancy before it
  always @(posedge clk) begin
    if (!rst) begin
      set_ovf = 1'b0;
      if (flush) begin
        model_q.delete();
        flush_seen = 1'b1;
      end else if (wr_en) begin
        if (model_q.size() >= DEPTH) set_ovf = 1'b1;
        else model_q.push_back(wr_data);
      end
      model_ovf = set_ovf | (model_ovf & ~err_clr);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      en_prev   = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (data_out_en && !en_prev) begin
        if (have_prev) chk("gap_ge2", {31'b0, low_cnt >= 2}, 32'd1);
        if (model_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected got %h want none", data_out);
        end else begin
          cur_word = model_q.pop_front();
          chk("issue_data", data_out, cur_word);
        end
        hold_cnt = 1;
      end else if (data_out_en) begin
        hold_cnt++;
        chk("data_stable", data_out, cur_word);
      end else if (en_prev) begin
        if (flush_seen) begin
          have_prev = 1'b0;
        end else begin
          chk("en_hold", hold_cnt, EN_HOLD);
          have_prev = 1'b1;
        end
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      en_prev = data_out_en;
      chk("level", {28'b0, level}, model_q.size());
      chk("full", {31'b0, full}, {31'b0, model_q.size() == DEPTH});
      chk("ovf", {31'b0, ovf}, {31'b0, model_ovf});
      flush_seen = 1'b0;
    end
  end

  task automatic put(input logic [31:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = w;
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // returns at the first negedge with the FSM waiting for completion
  task automatic wait_wait_state();
    int n = 0;
    @(negedge clk);
    while (!(busy && !data_out_en) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait", {31'b0, busy && !data_out_en}, 32'd1);
  endtask

  task automatic pulse_done(input int d);
    wait_wait_state();
    repeat (d) @(negedge clk);
    txd_valid = 1'b1;
    @(posedge clk); #1;
    chk("sent_e1", {16'b0, sent_cnt}, exp_sent);
    @(posedge clk); #1;
    chk("sent_e2", {16'b0, sent_cnt}, exp_sent);
    @(posedge clk); #1;
    exp_sent++;
    chk("sent_e3", {16'b0, sent_cnt}, exp_sent);
    chk("busy_gap", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("busy_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    txd_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, data_out, 32'd0);
    chk({tag, "_en"}, {31'b0, data_out_en}, 32'd0);
    chk({tag, "_full"}, {31'b0, full}, 32'd0);
    chk({tag, "_level"}, {28'b0, level}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_ovf"}, {31'b0, ovf}, 32'd0);
    chk({tag, "_tmo"}, {31'b0, tmo}, 32'd0);
    chk({tag, "_sent"}, {16'b0, sent_cnt}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic        ovf_before;
    int          n;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // single word, completion ~40 cycles after issue
    put(32'hA5A5_0001);
    idle();
    pulse_done(24);
    chk("data_kept", data_out, 32'hA5A5_0001);

    // fill past full: one popped, eight stored, last dropped
    for (int i = 0; i < 10; i++) put(32'h10 + i);
    idle();
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_level", {28'b0, level}, DEPTH);
    chk("fill_ovf", {31'b0, ovf}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk("ovf_clr", {31'b0, ovf}, 32'd0);
    @(negedge clk);
    err_clr = 1'b0;
    for (int i = 0; i < 9; i++) pulse_done($urandom_range(1, 60));
    chk("fill_sent", {16'b0, sent_cnt}, exp_sent);

    // ordering
    for (int i = 1; i <= 4; i++) put(i);
    idle();
    for (int i = 0; i < 4; i++) pulse_done($urandom_range(1, 60));

    // randomized bursts
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        put(w);
        if ($urandom_range(0, 1) == 1) idle();
      end
      idle();
      for (int i = 0; i < n; i++) pulse_done($urandom_range(1, 60));
    end

    // timeout
    put(32'h7777_0001);
    idle();
    wait_wait_state();
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("tmo_early", {31'b0, tmo}, 32'd0);
    chk("tmo_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("tmo_set", {31'b0, tmo}, 32'd1);
    chk("tmo_idle", {31'b0, busy}, 32'd0);
    chk("tmo_sent", {16'b0, sent_cnt}, exp_sent);
    put(32'h7777_0002);
    idle();
    pulse_done($urandom_range(1, 60));
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk("tmo_clr", {31'b0, tmo}, 32'd0);
    @(negedge clk);
    err_clr = 1'b0;

    // flush during ISSUE with a concurrent write
    for (int i = 1; i <= 4; i++) put(32'hF000_0000 + i);
    ovf_before = model_ovf;
    @(negedge clk);
    flush   = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("flush_en", {31'b0, data_out_en}, 32'd0);
    chk("flush_level", {28'b0, level}, 32'd0);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_ovf", {31'b0, ovf}, {31'b0, ovf_before});
    @(negedge clk);
    flush = 1'b0;
    wr_en = 1'b0;
    txd_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_sent", {16'b0, sent_cnt}, exp_sent);
    chk("flush_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    txd_valid = 1'b0;

    // asynchronous reset mid-WAIT
    put(32'hC0DE_0001);
    idle();
    wait_wait_state();
    #2;
    rst = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    exp_sent  = 0;
    #1;
    chk_all_zero("arst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    put(32'hC0DE_0002);
    @(posedge clk); #1;
    chk("lat_level0", {28'b0, level}, 32'd1);
    chk("lat_en0", {31'b0, data_out_en}, 32'd0);
    idle();
    @(posedge clk); #1;
    chk("lat_en1", {31'b0, data_out_en}, 32'd1);
    chk("lat_data", data_out, 32'hC0DE_0002);
    chk("lat_level1", {28'b0, level}, 32'd0);
    pulse_done($urandom_range(1, 60));

    repeat (3) @(negedge clk);
    chk("end_model", model_q.size(), 32'd0);
    chk("end_busy", {31'b0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
